// File: rtl/y86_bus_arbiter.sv
// Memory-bus arbiter for the y86 sequential core: the core always owns the bus,
// a single-entry secondary port (DMA/debug loader) uses cycles the core leaves idle.
module y86_bus_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    core_A,
    input  logic [DW-1:0]    core_out,
    input  logic             core_WE,
    input  logic             core_RE,
    output logic [DW-1:0]    core_in,
    output logic [AW-1:0]    mem_A,
    output logic [DW-1:0]    mem_out,
    output logic             mem_WE,
    output logic             mem_RE,
    input  logic [DW-1:0]    mem_in,
    input  logic             s_req,
    input  logic             s_we,
    input  logic [AW-1:0]    s_addr,
    input  logic [DW-1:0]    s_wdata,
    output logic             s_ready,
    output logic             s_ack,
    output logic [DW-1:0]    s_rdata,
    output logic             s_starve,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] block_cnt
);

    typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

    localparam int WC_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(WAIT_LIMIT);

    state_t          state, state_nxt;
    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [WC_W-1:0] wait_cnt;
    logic            core_busy;

    // The core has no stall input, so its path never passes through a register.
    assign core_busy = core_RE | core_WE;
    assign core_in   = mem_in;
    assign s_starve  = (state == PEND) && (wait_cnt >= WAIT_MAX);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_A   = '0;
        mem_out = '0;
        mem_WE  = 1'b0;
        mem_RE  = 1'b0;
        if (core_busy) begin
            mem_A   = core_A;
            mem_out = core_out;
            mem_WE  = core_WE;
            mem_RE  = core_RE;
        end else if (state == PEND) begin
            mem_A   = lat_addr;
            mem_out = lat_wdata;
            mem_WE  = lat_we;
            mem_RE  = !lat_we;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        s_ack     = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_req) state_nxt = PEND;
            end
            PEND: begin
                if (!core_busy) state_nxt = RESP;
            end
            RESP: begin
                s_ack     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched request is cleared too, so a reset mid-transfer can never replay stale data.
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            s_rdata   <= '0;
            grant_cnt <= '0;
            block_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && s_req) begin
                lat_we    <= s_we;
                lat_addr  <= s_addr;
                lat_wdata <= s_wdata;
                wait_cnt  <= '0;
            end
            if (state == PEND) begin
                if (!core_busy) begin
                    if (!lat_we) s_rdata <= mem_in;
                    if (grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
                end else begin
                    if (block_cnt != '1) block_cnt <= block_cnt + 1'b1;
                    if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Directed bench for y86_bus_arbiter (WAIT_LIMIT=4, CNT_W=4) with a combinational memory model.
module tb_y86_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_A, core_out, core_in;
    logic        core_WE, core_RE;
    logic [31:0] mem_A, mem_out, mem_in;
    logic        mem_WE, mem_RE;
    logic        s_req, s_we, s_ready, s_ack, s_starve;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  grant_cnt, block_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    assign mem_in = mem_fn(mem_A);

    y86_bus_arbiter #(.DW(32), .AW(32), .WAIT_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .core_A(core_A), .core_out(core_out), .core_WE(core_WE), .core_RE(core_RE),
        .core_in(core_in),
        .mem_A(mem_A), .mem_out(mem_out), .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_in(mem_in),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_ack(s_ack), .s_rdata(s_rdata), .s_starve(s_starve),
        .grant_cnt(grant_cnt), .block_cnt(block_cnt)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_A = '0; core_out = '0; core_WE = 1'b0; core_RE = 1'b0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total += 6;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", s_ready); end
        if (s_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", s_ack); end
        if ({mem_RE, mem_WE} !== 2'b00) begin bad++; $display("FAIL reset_en got %b want 00", {mem_RE, mem_WE}); end
        if (s_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", s_rdata); end
        if ({grant_cnt, block_cnt} !== 8'h00) begin bad++; $display("FAIL reset_cnt got %h want 00", {grant_cnt, block_cnt}); end
        if (s_starve !== 1'b0) begin bad++; $display("FAIL reset_starve got %b want 0", s_starve); end
    endtask

    task automatic test_read();
        next_cycle();
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h40;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got %b want 1", s_ready); end
        next_cycle();                            // N+1: issue; new request must be ignored
        s_addr = 32'h999;
        @(negedge clk);
        total += 3;
        if ({mem_RE, mem_WE} !== 2'b10) begin bad++; $display("FAIL rd_issue_en got %b want 10", {mem_RE, mem_WE}); end
        if (mem_A !== 32'h40) begin bad++; $display("FAIL rd_issue_addr got %h want 40", mem_A); end
        if ({s_ack, s_ready} !== 2'b00) begin bad++; $display("FAIL rd_issue_hs got %b want 00", {s_ack, s_ready}); end
        next_cycle();                            // N+2: ack
        @(negedge clk);
        total += 3;
        if (s_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got %b want 1", s_ack); end
        if (s_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got %h want deadbeef", s_rdata); end
        if ({grant_cnt, block_cnt} !== 8'h10) begin bad++; $display("FAIL rd_cnt got %h want 10", {grant_cnt, block_cnt}); end
        next_cycle();                            // N+3: back to idle
        s_req = 1'b0;
        @(negedge clk);
        total += 3;
        if ({s_ack, s_ready} !== 2'b01) begin bad++; $display("FAIL rd_after got %b want 01", {s_ack, s_ready}); end
        if (mem_RE !== 1'b0) begin bad++; $display("FAIL rd_ignored_req got %b want 0", mem_RE); end
        if (s_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got %h want deadbeef", s_rdata); end
    endtask

    task automatic test_write_blocked();
        next_cycle();
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h80; s_wdata = 32'h1234;
        next_cycle();
        s_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_RE = 1'b1; core_A = 32'h100 + 32'(i * 4);
            @(negedge clk);
            total += 2;
            if (mem_A !== 32'h100 + 32'(i * 4)) begin bad++; $display("FAIL wr_core_addr%0d got %h want %h", i, mem_A, 32'h100 + 32'(i * 4)); end
            if ({mem_RE, mem_WE, s_ready} !== 3'b100) begin bad++; $display("FAIL wr_core_en%0d got %b want 100", i, {mem_RE, mem_WE, s_ready}); end
            next_cycle();
        end
        core_RE = 1'b0;
        @(negedge clk);
        total += 3;
        if ({mem_RE, mem_WE} !== 2'b01) begin bad++; $display("FAIL wr_issue_en got %b want 01", {mem_RE, mem_WE}); end
        if ({mem_A, mem_out} !== {32'h80, 32'h1234}) begin bad++; $display("FAIL wr_issue_bus got %h/%h want 80/1234", mem_A, mem_out); end
        if (s_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack got %b want 0", s_ack); end
        next_cycle();
        @(negedge clk);
        total += 3;
        if (s_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got %b want 1", s_ack); end
        if ({grant_cnt, block_cnt} !== 8'h23) begin bad++; $display("FAIL wr_cnt got %h want 23", {grant_cnt, block_cnt}); end
        if (s_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rdata_kept got %h want deadbeef", s_rdata); end
    endtask

    task automatic test_illegal();
        next_cycle();
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h300;
        next_cycle();
        s_req = 1'b0; core_RE = 1'b1; core_WE = 1'b1; core_A = 32'h500; core_out = 32'hCAFE;
        @(negedge clk);
        total += 2;
        if ({mem_RE, mem_WE} !== 2'b11) begin bad++; $display("FAIL ill_en got %b want 11", {mem_RE, mem_WE}); end
        if ({mem_A, mem_out} !== {32'h500, 32'hCAFE}) begin bad++; $display("FAIL ill_bus got %h/%h want 500/cafe", mem_A, mem_out); end
        next_cycle();
        core_RE = 1'b0; core_WE = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_RE, mem_A} !== {1'b1, 32'h300}) begin bad++; $display("FAIL ill_issue got %b/%h want 1/300", mem_RE, mem_A); end
        next_cycle();
        @(negedge clk);
        total += 2;
        if ({s_ack, s_rdata} !== {1'b1, 32'h5A5A0311}) begin bad++; $display("FAIL ill_ack got %b/%h want 1/5a5a0311", s_ack, s_rdata); end
        if ({grant_cnt, block_cnt} !== 8'h34) begin bad++; $display("FAIL ill_cnt got %h want 34", {grant_cnt, block_cnt}); end
    endtask

    task automatic test_starve();
        do_reset();
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h44;
        next_cycle();
        s_req = 1'b0;
        for (int j = 0; j < 6; j++) begin
            core_RE = 1'b1; core_A = 32'h600;
            @(negedge clk);
            total++;
            if (s_starve !== (j >= 4)) begin bad++; $display("FAIL starve_blk%0d got %b want %b", j, s_starve, (j >= 4)); end
            next_cycle();
        end
        core_RE = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_RE, mem_A} !== {1'b1, 32'h44}) begin bad++; $display("FAIL starve_issue got %b/%h want 1/44", mem_RE, mem_A); end
        next_cycle();
        @(negedge clk);
        total += 2;
        if ({s_ack, s_starve} !== 2'b10) begin bad++; $display("FAIL starve_clear got %b want 10", {s_ack, s_starve}); end
        if (block_cnt !== 4'd6) begin bad++; $display("FAIL starve_block got %0d want 6", block_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h70; s_wdata = 32'h5;
        next_cycle();
        s_req = 1'b0;
        for (int j = 0; j < 20; j++) begin
            core_WE = 1'b1; core_A = 32'h700;
            @(negedge clk);
            total++;
            if (block_cnt !== 4'((j > 15) ? 15 : j)) begin bad++; $display("FAIL sat_blk%0d got %0d want %0d", j, block_cnt, (j > 15) ? 15 : j); end
            next_cycle();
        end
        core_WE = 1'b0;
        next_cycle();
        @(negedge clk);
        total += 2;
        if (s_ack !== 1'b1) begin bad++; $display("FAIL sat_ack got %b want 1", s_ack); end
        if ({grant_cnt, block_cnt} !== 8'h1F) begin bad++; $display("FAIL sat_cnt got %h want 1f", {grant_cnt, block_cnt}); end
    endtask

    task automatic test_reset_mid_pend();
        do_reset();
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h90; s_wdata = 32'hAA;
        next_cycle();
        s_req = 1'b0; core_RE = 1'b1; core_A = 32'h900;
        next_cycle();
        core_RE = 1'b0;
        @(negedge clk);
        total += 2;
        if ({mem_WE, mem_A} !== {1'b1, 32'h90}) begin bad++; $display("FAIL rp_pre got %b/%h want 1/90", mem_WE, mem_A); end
        if (block_cnt !== 4'd1) begin bad++; $display("FAIL rp_pre_blk got %0d want 1", block_cnt); end
        #2 rst = 1'b1;
        #1;
        total += 3;
        if ({mem_WE, mem_RE} !== 2'b00) begin bad++; $display("FAIL rp_en got %b want 00", {mem_WE, mem_RE}); end
        if ({s_ready, s_ack} !== 2'b10) begin bad++; $display("FAIL rp_hs got %b want 10", {s_ready, s_ack}); end
        if ({grant_cnt, block_cnt} !== 8'h00) begin bad++; $display("FAIL rp_cnt got %h want 00", {grant_cnt, block_cnt}); end
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++;
            if ({s_ack, mem_WE, mem_RE} !== 3'b000) begin bad++; $display("FAIL rp_after%0d got %b want 000", j, {s_ack, mem_WE, mem_RE}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pend_q[$];
        logic [31:0] exp_a;
        int          issued = 0;
        int          acks   = 0;
        int          cyc    = 0;
        bit          accepted = 1'b0;
        logic        c_re, c_we;
        logic [31:0] c_a;
        do_reset();
        @(negedge clk);
        while (acks < 10 && cyc < 400) begin
            next_cycle();
            if (accepted) begin
                pend_q.push_back(32'h200 + 32'(issued * 8));
                issued++;
            end
            c_re = (cyc % 5 == 0) || (cyc % 5 == 3 && cyc % 2 == 0);
            c_we = (cyc % 5 == 3 && cyc % 2 == 1);
            c_a  = 32'h1000 + 32'(cyc);
            core_RE = c_re; core_WE = c_we; core_A = c_a; core_out = ~c_a;
            s_req = (issued < 10); s_we = 1'b0; s_addr = 32'h200 + 32'(issued * 8);
            @(negedge clk);
            total++;
            if (core_in !== mem_fn(mem_A)) begin bad++; $display("FAIL b2b_core_in c%0d got %h want %h", cyc, core_in, mem_fn(mem_A)); end
            if (c_re || c_we) begin
                total++;
                if ({mem_A, mem_out, mem_RE, mem_WE} !== {c_a, ~c_a, c_re, c_we}) begin
                    bad++; $display("FAIL b2b_core_bus c%0d got %h/%b%b want %h/%b%b", cyc, mem_A, mem_RE, mem_WE, c_a, c_re, c_we);
                end
            end
            if (s_ack) begin
                exp_a = (pend_q.size() > 0) ? pend_q.pop_front() : 32'hFFFF_FFFF;
                total++;
                if (s_rdata !== mem_fn(exp_a)) begin bad++; $display("FAIL b2b_rdata%0d got %h want %h", acks, s_rdata, mem_fn(exp_a)); end
                acks++;
            end
            accepted = s_ready && s_req;
            cyc++;
        end
        s_req = 1'b0;
        core_RE = 1'b0; core_WE = 1'b0;
        total += 2;
        if (acks != 10) begin bad++; $display("FAIL b2b_acks got %0d want 10", acks); end
        if (grant_cnt !== 4'd10) begin bad++; $display("FAIL b2b_grants got %0d want 10", grant_cnt); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_blocked();
        test_illegal();
        test_starve();
        test_saturate();
        test_reset_mid_pend();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
